// File: rtl/vga_scan.sv
// 640x480 VGA scan generator showing a 256x240 frame buffer at 2x with 64-pixel side borders.
// Define VGA_BORDER_COLOR_EN to drive BORDER_RGB in the visible area outside the picture window.
module vga_scan #(
  parameter logic [8:0] BORDER_RGB = 9'h000,
  parameter int         H_VIS      = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_VIS      = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33
) (
  input  logic       pix_clk,
  input  logic       reset_n,
  input  logic [8:0] rgb,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_de,
  output logic       vblank,
  output logic       frame_start
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int WIN_X0 = 64;
  localparam int WIN_X1 = 576;

`ifdef VGA_BORDER_COLOR_EN
  localparam logic [8:0] BORDER = BORDER_RGB;
`else
  localparam logic [8:0] BORDER = BORDER_RGB & 9'h000;
`endif

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0};

  logic [9:0] r_h_cnt, r_v_cnt;
  ctl_t       r_ctl_d1;
  logic       r_hs, r_vs, r_de;
  logic [8:0] r_col;

  logic       w_h_vis, w_v_vis, w_win;
  ctl_t       w_ctl;
  logic [8:0] w_col;

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == 10'(H_TOT - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == 10'(V_TOT - 1)) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign w_h_vis = (r_h_cnt < 10'(H_VIS));
  assign w_v_vis = (r_v_cnt < 10'(V_VIS));
  assign w_win   = (r_h_cnt >= 10'(WIN_X0)) && (r_h_cnt < 10'(WIN_X1)) && w_v_vis;

  always_comb begin
    w_ctl     = CTL_RST;
    w_ctl.hs  = !((r_h_cnt >= 10'(HS_BEG)) && (r_h_cnt < 10'(HS_END)));
    w_ctl.vs  = !((r_v_cnt >= 10'(VS_BEG)) && (r_v_cnt < 10'(VS_END)));
    w_ctl.de  = w_h_vis && w_v_vis;
    w_ctl.win = w_win;
  end

  // Each frame-buffer pixel spans two columns and two rows of the scan.
  assign pix_ptr_x   = w_win ? 8'((r_h_cnt - 10'(WIN_X0)) >> 1) : 8'd0;
  assign pix_ptr_y   = w_win ? 8'(r_v_cnt >> 1) : 8'd0;
  assign vblank      = !w_v_vis;
  assign frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'(V_VIS));

  // Stage 1 waits for the frame buffer read; stage 2 merges the returned pixel.
  always_comb begin
    w_col = 9'h000;
    if (r_ctl_d1.win)     w_col = rgb;
    else if (r_ctl_d1.de) w_col = BORDER;
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctl_d1 <= CTL_RST;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_de     <= 1'b0;
      r_col    <= '0;
    end else begin
      r_ctl_d1 <= w_ctl;
      r_hs     <= r_ctl_d1.hs;
      r_vs     <= r_ctl_d1.vs;
      r_de     <= r_ctl_d1.de;
      r_col    <= w_col;
    end
  end

  assign hsync  = r_hs;
  assign vsync  = r_vs;
  assign vga_de = r_de;
  assign vga_r  = r_col[8:6];
  assign vga_g  = r_col[5:3];
  assign vga_b  = r_col[2:0];

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: a full-timing instance for line/pixel behaviour and a
// short-frame instance (8 visible + 7 blank lines) so vertical events fit a short run.
module tb_vga_scan;

  localparam logic [8:0] BRGB = 9'h1C0;
`ifdef VGA_BORDER_COLOR_EN
  localparam logic [8:0] EXP_BORDER = BRGB;
`else
  localparam logic [8:0] EXP_BORDER = 9'h000;
`endif

  logic       pix_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] rgb0 = '0, rgb1 = '0;
  logic [7:0] px0, py0, px1, py1;
  logic [2:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, de0, vb0, fs0;
  logic       hs1, vs1, de1, vb1, fs1;
  logic [8:0] col0, col1;

  int n;
  int vec = 0;
  int err = 0;

  always #5 pix_clk = ~pix_clk;

  // Frame-buffer models: one-cycle read latency.
  always @(posedge pix_clk) begin
    rgb0 <= {py0[2:0], px0[2:0], 3'b011};
    rgb1 <= {py1[2:0], px1[2:0], 3'b011};
  end

  assign col0 = {r0, g0, b0};
  assign col1 = {r1, g1, b1};

  vga_scan #(.BORDER_RGB(BRGB)) u_dut (
    .pix_clk(pix_clk), .reset_n(reset_n), .rgb(rgb0),
    .pix_ptr_x(px0), .pix_ptr_y(py0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .hsync(hs0), .vsync(vs0), .vga_de(de0), .vblank(vb0), .frame_start(fs0)
  );

  vga_scan #(.BORDER_RGB(BRGB), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_dut_v (
    .pix_clk(pix_clk), .reset_n(reset_n), .rgb(rgb1),
    .pix_ptr_x(px1), .pix_ptr_y(py1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .hsync(hs1), .vsync(vs1), .vga_de(de1), .vblank(vb1), .frame_start(fs1)
  );

  // n = counter-state index since reset release; outputs show state n-2.
  task automatic tick();
    @(posedge pix_clk);
    @(negedge pix_clk);
    n++;
  endtask

  task automatic goto(input int target);
    while (n < target) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge pix_clk);
    vec++; if (col0 !== 9'h000) begin err++; $display("FAIL rst_col: got %h want 000", col0); end
    vec++; if (hs0 !== 1'b1 || vs0 !== 1'b1) begin err++; $display("FAIL rst_sync: got hs=%b vs=%b want 1 1", hs0, vs0); end
    vec++; if (de0 !== 1'b0) begin err++; $display("FAIL rst_de: got %b want 0", de0); end
    vec++; if (vb0 !== 1'b0 || fs0 !== 1'b0) begin err++; $display("FAIL rst_vb_fs: got vb=%b fs=%b want 0 0", vb0, fs0); end
    vec++; if (px0 !== 8'd0 || py0 !== 8'd0) begin err++; $display("FAIL rst_ptr: got x=%0d y=%0d want 0 0", px0, py0); end
    vec++; if (hs1 !== 1'b1 || vs1 !== 1'b1 || col1 !== 9'h000) begin err++; $display("FAIL rst_v: got hs=%b vs=%b col=%h want 1 1 000", hs1, vs1, col1); end
    reset_n = 1'b1;
    n = 0;
  endtask

  task automatic test_first_pixel();
    goto(1);
    vec++; if (de0 !== 1'b0) begin err++; $display("FAIL first_de_n1: got %b want 0", de0); end
    goto(2);
    vec++; if (de0 !== 1'b1) begin err++; $display("FAIL first_de_n2: got %b want 1", de0); end
    vec++; if (col0 !== EXP_BORDER) begin err++; $display("FAIL first_col: got %h want %h", col0, EXP_BORDER); end
    vec++; if (hs0 !== 1'b1) begin err++; $display("FAIL first_hs: got %b want 1", hs0); end
  endtask

  task automatic test_hsync();
    int lo = 0, first = -1, de_cnt = 0;
    goto(2);
    while (n <= 801) begin
      if (!hs0) begin lo++; if (first < 0) first = n - 2; end
      if (de0) de_cnt++;
      tick();
    end
    vec++; if (lo != 96) begin err++; $display("FAIL hsync_width: got %0d want 96", lo); end
    vec++; if (first != 656) begin err++; $display("FAIL hsync_start: got %0d want 656", first); end
    vec++; if (de_cnt != 640) begin err++; $display("FAIL de_width: got %0d want 640", de_cnt); end
  endtask

  task automatic test_pixels();
    int ks[6] = '{0, 1, 5, 8, 127, 254};
    foreach (ks[i]) begin
      int base = 2 * 800 + 64 + 2 * ks[i];
      logic [7:0] kk = 8'(ks[i]);
      logic [8:0] exp = {3'd1, kk[2:0], 3'b011};
      goto(base);
      vec++; if (px0 !== kk || py0 !== 8'd1) begin err++; $display("FAIL pix_ptr k=%0d: got x=%0d y=%0d want %0d 1", ks[i], px0, py0, kk); end
      goto(base + 2);
      vec++; if (col0 !== exp) begin err++; $display("FAIL pix_even k=%0d: got %h want %h", ks[i], col0, exp); end
      goto(base + 3);
      vec++; if (col0 !== exp) begin err++; $display("FAIL pix_odd k=%0d: got %h want %h", ks[i], col0, exp); end
    end
  endtask

  task automatic test_window_edge();
    int base = 4 * 800;
    goto(base + 575);
    vec++; if (px0 !== 8'd255 || py0 !== 8'd2) begin err++; $display("FAIL edge_575: got x=%0d y=%0d want 255 2", px0, py0); end
    goto(base + 576);
    vec++; if (px0 !== 8'd0 || py0 !== 8'd0) begin err++; $display("FAIL edge_576: got x=%0d y=%0d want 0 0", px0, py0); end
    goto(base + 577);
    vec++; if (col0 !== 9'b010_111_011) begin err++; $display("FAIL edge_col575: got %h want %h", col0, 9'b010_111_011); end
    goto(base + 578);
    vec++; if (col0 !== EXP_BORDER || de0 !== 1'b1) begin err++; $display("FAIL edge_col576: got col=%h de=%b want %h 1", col0, de0, EXP_BORDER); end
  endtask

  task automatic test_border();
    int base = 6 * 800;
    goto(base + 12);
    vec++; if (col0 !== EXP_BORDER || de0 !== 1'b1) begin err++; $display("FAIL border_left: got col=%h de=%b want %h 1", col0, de0, EXP_BORDER); end
    goto(base + 641);
    vec++; if (col0 !== EXP_BORDER || de0 !== 1'b1) begin err++; $display("FAIL border_right: got col=%h de=%b want %h 1", col0, de0, EXP_BORDER); end
    goto(base + 642);
    vec++; if (col0 !== 9'h000 || de0 !== 1'b0) begin err++; $display("FAIL blank_640: got col=%h de=%b want 000 0", col0, de0); end
    goto(base + 702);
    vec++; if (col0 !== 9'h000 || de0 !== 1'b0 || hs0 !== 1'b0) begin err++; $display("FAIL blank_700: got col=%h de=%b hs=%b want 000 0 0", col0, de0, hs0); end
    vec++; if (vb0 !== 1'b0) begin err++; $display("FAIL vblank_vis: got %b want 0", vb0); end
  endtask

  task automatic test_window_y();
    goto(7 * 800 + 100);
    vec++; if (px1 !== 8'd18 || py1 !== 8'd3) begin err++; $display("FAIL win_last_row: got x=%0d y=%0d want 18 3", px1, py1); end
    goto(8 * 800 + 100);
    vec++; if (px1 !== 8'd0 || py1 !== 8'd0 || vb1 !== 1'b1) begin err++; $display("FAIL win_below: got x=%0d y=%0d vb=%b want 0 0 1", px1, py1, vb1); end
    vec++; if (px0 !== 8'd18 || py0 !== 8'd4) begin err++; $display("FAIL win_full_row8: got x=%0d y=%0d want 18 4", px0, py0); end
  endtask

  task automatic test_vframe();
    int vb_cnt = 0, fs_cnt = 0, fs_at = -1, vs_lo = 0, vs_first = -1, hs_lo = 0, de_cnt = 0;
    int vb0_cnt = 0, vs0_lo = 0;
    goto(12000);
    while (n <= 24001) begin
      if (n < 24000) begin
        if (vb1) vb_cnt++;
        if (fs1) begin fs_cnt++; fs_at = n; end
        if (vb0) vb0_cnt++;
      end
      if (n >= 12002) begin
        if (!vs1) begin vs_lo++; if (vs_first < 0) vs_first = n; end
        if (!hs1) hs_lo++;
        if (de1) de_cnt++;
        if (!vs0) vs0_lo++;
      end
      tick();
    end
    vec++; if (vb_cnt != 5600) begin err++; $display("FAIL vblank_len: got %0d want 5600", vb_cnt); end
    vec++; if (fs_cnt != 1) begin err++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
    vec++; if (fs_at != 18400) begin err++; $display("FAIL fs_pos: got %0d want 18400", fs_at); end
    vec++; if (vs_lo != 1600) begin err++; $display("FAIL vsync_width: got %0d want 1600", vs_lo); end
    vec++; if (vs_first != 20002) begin err++; $display("FAIL vsync_start: got %0d want 20002", vs_first); end
    vec++; if (hs_lo != 1440) begin err++; $display("FAIL hsync_frame: got %0d want 1440", hs_lo); end
    vec++; if (de_cnt != 5120) begin err++; $display("FAIL de_frame: got %0d want 5120", de_cnt); end
    vec++; if (vb0_cnt != 0 || vs0_lo != 0) begin err++; $display("FAIL full_no_vert: got vb=%0d vs=%0d want 0 0", vb0_cnt, vs0_lo); end
  endtask

  task automatic test_midframe_reset();
    goto(24000 + 11 * 800 + 700);
    vec++; if (hs1 !== 1'b0 || vs1 !== 1'b0) begin err++; $display("FAIL pre_rst_sync: got hs=%b vs=%b want 0 0", hs1, vs1); end
    #1 reset_n = 1'b0;
    #1;
    vec++; if (hs1 !== 1'b1 || vs1 !== 1'b1) begin err++; $display("FAIL mid_rst_sync: got hs=%b vs=%b want 1 1", hs1, vs1); end
    vec++; if (col1 !== 9'h000 || de1 !== 1'b0 || vb1 !== 1'b0) begin err++; $display("FAIL mid_rst_out: got col=%h de=%b vb=%b want 000 0 0", col1, de1, vb1); end
    vec++; if (px1 !== 8'd0 || py1 !== 8'd0) begin err++; $display("FAIL mid_rst_ptr: got x=%0d y=%0d want 0 0", px1, py1); end
    @(negedge pix_clk);
    reset_n = 1'b1;
    n = 0;
    goto(2);
    vec++; if (de1 !== 1'b1 || hs1 !== 1'b1 || vs1 !== 1'b1) begin err++; $display("FAIL restart_n2: got de=%b hs=%b vs=%b want 1 1 1", de1, hs1, vs1); end
    goto(66);
    vec++; if (px1 !== 8'd1 || py1 !== 8'd0) begin err++; $display("FAIL restart_ptr: got x=%0d y=%0d want 1 0", px1, py1); end
    goto(657);
    vec++; if (hs1 !== 1'b1) begin err++; $display("FAIL restart_hs655: got %b want 1", hs1); end
    goto(658);
    vec++; if (hs1 !== 1'b0) begin err++; $display("FAIL restart_hs656: got %b want 0", hs1); end
  endtask

  initial begin
    n = 0;
    test_reset();
    test_first_pixel();
    test_hsync();
    test_pixels();
    test_window_edge();
    test_border();
    test_window_y();
    test_vframe();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
